fetch_decode_stage: RTL and testbench

First pipeline stage of the 32-bit RV32I-subset CPU. It holds the 5-bit program counter and fetches instructions from a 32-word synchronous instruction ROM. It reads operands from a 32×32 register file with write-through bypass, and decodes control signals and the immediate for the execute stage. Writeback and branch resolution arrive from later stages through `in_*` / `jump_*` ports.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/decoder.sv | 125 ++++++++++++
 rtl/instr_rom.sv | 23 ++
 rtl/reg_file.sv | 43 ++++
 rtl/fetch_decode_stage.sv | 82 ++++++++
 tb/tb_fetch_decode_stage.sv | 249 ++++++++++++++++++++++++
 6 files changed

// File: rtl/cpu_pkg.sv
// Shared opcodes, ALU/branch enumerations and constants
// for the RV32I-subset fetch/decode front end.
package cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_SLL   = 5'd2,
    ALU_SLT   = 5'd3,
    ALU_SLTU  = 5'd4,
    ALU_XOR   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_OR    = 5'd8,
    ALU_AND   = 5'd9,
    ALU_PASSB = 5'd10
  } alu_op_e;

  typedef enum logic [3:0] {
    JT_NONE = 4'd0,
    JT_JAL  = 4'd1,
    JT_JALR = 4'd2,
    JT_BEQ  = 4'd3,
    JT_BNE  = 4'd4,
    JT_BLT  = 4'd5,
    JT_BGE  = 4'd6,
    JT_BLTU = 4'd7,
    JT_BGEU = 4'd8
  } jump_type_e;

endpackage

// File: rtl/decoder.sv
// Combinational control and immediate generation
// for the supported RV32I opcodes.
module decoder (
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o,
  output logic        reg_wr_o,
  output logic        mem_wr_o,
  output logic        mem_to_reg_o,
  output logic        alu_src_o,
  output logic [4:0]  alu_op_o,
  output logic [3:0]  jump_type_o,
  output logic        halt_o
);
  import cpu_pkg::*;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        alt;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  alu_op_e     arith_op;
  jump_type_e  br_type;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign alt    = instr_i[30];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25],
                  instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31],
                  instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31],
                  instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};
  assign imm_u = {instr_i[31:12], 12'd0};

  assign halt_o = (opcode == OP_SYSTEM);

  // instr[30] means SUB only on register-register ops.
  always_comb begin
    arith_op = ALU_ADD;
    unique case (f3)
      3'd0: arith_op = (alt && opcode == OP_R)
                       ? ALU_SUB : ALU_ADD;
      3'd1: arith_op = ALU_SLL;
      3'd2: arith_op = ALU_SLT;
      3'd3: arith_op = ALU_SLTU;
      3'd4: arith_op = ALU_XOR;
      3'd5: arith_op = alt ? ALU_SRA : ALU_SRL;
      3'd6: arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  always_comb begin
    br_type = JT_NONE;
    unique case (f3)
      3'd0: br_type = JT_BEQ;
      3'd1: br_type = JT_BNE;
      3'd4: br_type = JT_BLT;
      3'd5: br_type = JT_BGE;
      3'd6: br_type = JT_BLTU;
      3'd7: br_type = JT_BGEU;
      default: br_type = JT_NONE;
    endcase
  end

  always_comb begin
    imm_o        = '0;
    reg_wr_o     = 1'b0;
    mem_wr_o     = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_o    = 1'b0;
    alu_op_o     = ALU_ADD;
    jump_type_o  = JT_NONE;
    unique case (1'b1)
      opcode == OP_R: begin
        reg_wr_o = 1'b1;
        alu_op_o = arith_op;
      end
      opcode == OP_IMM: begin
        reg_wr_o  = 1'b1;
        alu_src_o = 1'b1;
        alu_op_o  = arith_op;
        imm_o     = imm_i;
      end
      opcode == OP_LOAD: begin
        reg_wr_o     = 1'b1;
        mem_to_reg_o = 1'b1;
        alu_src_o    = 1'b1;
        imm_o        = imm_i;
      end
      opcode == OP_STORE: begin
        mem_wr_o  = 1'b1;
        alu_src_o = 1'b1;
        imm_o     = imm_s;
      end
      opcode == OP_BRANCH: begin
        alu_op_o    = ALU_SUB;
        jump_type_o = br_type;
        imm_o       = imm_b;
      end
      opcode == OP_JAL: begin
        reg_wr_o    = 1'b1;
        jump_type_o = JT_JAL;
        imm_o       = imm_j;
      end
      opcode == OP_JALR: begin
        reg_wr_o    = 1'b1;
        alu_src_o   = 1'b1;
        jump_type_o = JT_JALR;
        imm_o       = imm_i;
      end
      opcode == OP_LUI: begin
        reg_wr_o  = 1'b1;
        alu_src_o = 1'b1;
        alu_op_o  = ALU_PASSB;
        imm_o     = imm_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_rom.sv
// 32-word instruction ROM with a registered output;
// reset forces the output word to a NOP.
module instr_rom #(
  parameter string ROM_INIT = "program.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  addr_i,
  output logic [31:0] instr_o
);
  import cpu_pkg::*;

  logic [31:0] mem [32];
  logic [31:0] instr_q;

  always_ff @(posedge clk) begin
    if (rst) instr_q <= NOP;
    else     instr_q <= mem[addr_i];
  end

  assign instr_o = instr_q;

endmodule

// File: rtl/reg_file.sv
// 32x32 register file, two combinational reads with
// write-through bypass; x0 is hard-wired to zero.
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] regs_q [32];
  logic        wr_ok;

  assign wr_ok = we_i && (waddr_i != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (raddr1_i == 5'd0)
      rdata1_o = '0;
    else if (wr_ok && raddr1_i == waddr_i)
      rdata1_o = wdata_i;
  end

  always_comb begin
    rdata2_o = regs_q[raddr2_i];
    if (raddr2_i == 5'd0)
      rdata2_o = '0;
    else if (wr_ok && raddr2_i == waddr_i)
      rdata2_o = wdata_i;
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// Front-end stage: pc and sticky halt, ROM fetch,
// operand read and decode for execute.
module fetch_decode_stage #(
  parameter string ROM_INIT = "program.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  jump_pc,
  input  logic        should_jump,
  input  logic [4:0]  in_write_reg,
  input  logic [31:0] write_data,
  input  logic        in_reg_wrenable,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  output logic [31:0] imm,
  output logic [4:0]  out_write_reg,
  output logic        out_reg_wrenable,
  output logic [3:0]  jump_type,
  output logic        mem_wrenable,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [4:0]  alu_op,
  output logic [4:0]  pc
);
  logic [4:0]  pc_q, pc_d;
  logic        halted_q, halted_d;
  logic        halt;
  logic [31:0] instr;

  // A halted core ignores redirects until reset.
  always_comb begin
    pc_d     = pc_q + 5'd1;
    halted_d = halted_q | halt;
    if (halted_q)         pc_d = pc_q;
    else if (should_jump) pc_d = jump_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign pc            = pc_q;
  assign out_write_reg = instr[11:7];

  instr_rom #(.ROM_INIT(ROM_INIT)) u_rom (
    .clk     (clk),
    .rst     (rst),
    .addr_i  (pc_q),
    .instr_o (instr)
  );

  reg_file u_rf (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (instr[19:15]),
    .raddr2_i (instr[24:20]),
    .waddr_i  (in_write_reg),
    .wdata_i  (write_data),
    .we_i     (in_reg_wrenable),
    .rdata1_o (read_data1),
    .rdata2_o (read_data2)
  );

  decoder u_dec (
    .instr_i      (instr),
    .imm_o        (imm),
    .reg_wr_o     (out_reg_wrenable),
    .mem_wr_o     (mem_wrenable),
    .mem_to_reg_o (mem_to_reg),
    .alu_src_o    (alu_src),
    .alu_op_o     (alu_op),
    .jump_type_o  (jump_type),
    .halt_o       (halt)
  );

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: fetch order,
// jumps, halt, bypass and decode tables.
module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  jump_pc = '0;
  logic        should_jump = 1'b0;
  logic [4:0]  in_write_reg = '0;
  logic [31:0] write_data = '0;
  logic        in_reg_wrenable = 1'b0;
  logic [31:0] read_data1, read_data2, imm;
  logic [4:0]  out_write_reg, alu_op, pc;
  logic        out_reg_wrenable, mem_wrenable;
  logic        mem_to_reg, alu_src;
  logic [3:0]  jump_type;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_decode_stage #(.ROM_INIT("")) dut (
    .clk              (clk),
    .rst              (rst),
    .jump_pc          (jump_pc),
    .should_jump      (should_jump),
    .in_write_reg     (in_write_reg),
    .write_data       (write_data),
    .in_reg_wrenable  (in_reg_wrenable),
    .read_data1       (read_data1),
    .read_data2       (read_data2),
    .imm              (imm),
    .out_write_reg    (out_write_reg),
    .out_reg_wrenable (out_reg_wrenable),
    .jump_type        (jump_type),
    .mem_wrenable     (mem_wrenable),
    .mem_to_reg       (mem_to_reg),
    .alu_src          (alu_src),
    .alu_op           (alu_op),
    .pc               (pc)
  );

  // {imm, alu_op, jump_type, reg_wr, mem_wr, mem_to_reg, alu_src}
  logic [44:0] dec;
  assign dec = {imm, alu_op, jump_type, out_reg_wrenable,
                mem_wrenable, mem_to_reg, alu_src};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 32; i++) dut.u_rom.mem[i] = 32'h00000013;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic check_pc(input string nm, input logic [4:0] want);
    vectors++;
    if (pc !== want) begin
      miscompares++;
      $display("FAIL %s: pc got %0d want %0d", nm, pc, want);
    end
  endtask

  task automatic test_reset();
    logic [44:0] want;
    fill_nop();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_pc("reset_pc", 5'd0);
    want = {32'h0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    vectors++;
    if (dec !== want) begin
      miscompares++;
      $display("FAIL reset_decode: got %h want %h", dec, want);
    end
    vectors++;
    if (out_write_reg !== 5'd0 || read_data1 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rd: rd=%0d rs1data=%h want 0/0",
               out_write_reg, read_data1);
    end
  endtask

  task automatic test_fetch();
    fill_nop();
    for (int k = 0; k < 4; k++)
      dut.u_rom.mem[k] = ((k + 10) << 20) | ((k + 1) << 7) | 32'h13;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      check_pc("fetch_pc", 5'(k));
      step();
      vectors++;
      if (imm !== 32'(k + 10) || out_write_reg !== 5'(k + 1)) begin
        miscompares++;
        $display("FAIL fetch_word%0d: imm=%h rd=%0d want %h/%0d",
                 k, imm, out_write_reg, k + 10, k + 1);
      end
    end
    check_pc("fetch_pc_after", 5'd4);
  endtask

  task automatic test_jump_wrap();
    should_jump = 1'b1;
    jump_pc = 5'd20;
    step();
    check_pc("jump_20", 5'd20);
    jump_pc = 5'd31;
    step();
    check_pc("jump_31_back_to_back", 5'd31);
    should_jump = 1'b0;
    step();
    check_pc("wrap_to_0", 5'd0);
    step();
    check_pc("after_wrap", 5'd1);
  endtask

  task automatic test_halt();
    fill_nop();
    dut.u_rom.mem[8] = 32'h00000073;
    do_reset();
    repeat (9) step();
    check_pc("halt_fetched", 5'd9);
    step();
    check_pc("halt_latch_edge", 5'd10);
    step();
    check_pc("halt_frozen", 5'd10);
    should_jump = 1'b1;
    jump_pc = 5'd5;
    step();
    check_pc("halt_ignores_jump", 5'd10);
    should_jump = 1'b0;
    step();
    check_pc("halt_still", 5'd10);
    dut.u_rom.mem[8] = 32'h00000013;
    do_reset();
    check_pc("halt_reset", 5'd0);
    step();
    check_pc("halt_resume", 5'd1);
  endtask

  task automatic test_bypass();
    fill_nop();
    dut.u_rom.mem[0] = 32'h000280B3;
    dut.u_rom.mem[1] = 32'h000280B3;
    do_reset();
    step();
    in_reg_wrenable = 1'b1;
    in_write_reg = 5'd5;
    write_data = 32'hDEADBEEF;
    #1;
    vectors++;
    if (read_data1 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL bypass_rs1: got %h want deadbeef", read_data1);
    end
    step();
    in_reg_wrenable = 1'b0;
    #1;
    vectors++;
    if (read_data1 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL stored_x5: got %h want deadbeef", read_data1);
    end
    in_reg_wrenable = 1'b1;
    in_write_reg = 5'd0;
    write_data = 32'h12345678;
    #1;
    vectors++;
    if (read_data2 !== 32'h0) begin
      miscompares++;
      $display("FAIL x0_bypass: got %h want 0", read_data2);
    end
    step();
    in_reg_wrenable = 1'b0;
    #1;
    vectors++;
    if (read_data1 !== 32'h0) begin
      miscompares++;
      $display("FAIL x0_after_write: got %h want 0", read_data1);
    end
    do_reset();
    step();
    vectors++;
    if (read_data1 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_clears_x5: got %h want 0", read_data1);
    end
  endtask

  task automatic test_decode();
    logic [31:0] ins [12];
    logic [44:0] exp [12];
    ins[0]  = 32'hFFC4A303; exp[0]  = {32'hFFFFFFFC, 5'd0,  4'd0, 4'b1011};
    ins[1]  = 32'h40B50533; exp[1]  = {32'h0,        5'd1,  4'd0, 4'b1000};
    ins[2]  = 32'hFE0018E3; exp[2]  = {32'hFFFFFFF0, 5'd1,  4'd4, 4'b0000};
    ins[3]  = 32'h4030D093; exp[3]  = {32'h00000403, 5'd7,  4'd0, 4'b1001};
    ins[4]  = 32'h12345137; exp[4]  = {32'h12345000, 5'd10, 4'd0, 4'b1001};
    ins[5]  = 32'hFF9FF0EF; exp[5]  = {32'hFFFFFFF8, 5'd0,  4'd1, 4'b1000};
    ins[6]  = 32'h00512423; exp[6]  = {32'h00000008, 5'd0,  4'd0, 4'b0101};
    ins[7]  = 32'h0000007F; exp[7]  = {32'h0,        5'd0,  4'd0, 4'b0000};
    ins[8]  = 32'h004100E7; exp[8]  = {32'h00000004, 5'd0,  4'd2, 4'b1001};
    ins[9]  = 32'h400050B3; exp[9]  = {32'h0,        5'd7,  4'd0, 4'b1000};
    ins[10] = 32'h40000093; exp[10] = {32'h00000400, 5'd0,  4'd0, 4'b1001};
    ins[11] = 32'h00007063; exp[11] = {32'h0,        5'd1,  4'd8, 4'b0000};
    fill_nop();
    for (int i = 0; i < 12; i++) dut.u_rom.mem[i] = ins[i];
    do_reset();
    step();
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (dec !== exp[i]) begin
        miscompares++;
        $display("FAIL decode_%0d (%h): got %h want %h",
                 i, ins[i], dec, exp[i]);
      end
      if (i == 0) begin
        vectors++;
        if (out_write_reg !== 5'd6) begin
          miscompares++;
          $display("FAIL lw_rd: got %0d want 6", out_write_reg);
        end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_jump_wrap();
    test_halt();
    test_bypass();
    test_decode();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
